// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - issue, ALU and writeback signal bundle for alu_seq_ctrl
//
// Ports (all 64-bit buses use big-endian numbering, bit 0 is the MSB):
//   req_*  : issue-side valid/ready handshake with opcode, lane width, immediate, operands, tag
//   alu_*  : registered operand/control drive to the multicycle ALU, alu_dout back from it
//   res_*  : writeback-side valid/ready handshake with result, tag and error flag
//   busy   : sequencer is not idle
// Modports: slave = the sequencer, master = the surrounding issue/ALU/writeback logic.
interface alu_seq_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [0:5]       req_type;
    logic [0:1]       req_ww;
    logic [0:4]       req_imm;
    logic [0:63]      req_a;
    logic [0:63]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic             alu_en;
    logic [0:5]       alu_type;
    logic [0:1]       alu_ww;
    logic [0:4]       alu_imm;
    logic [0:63]      alu_a;
    logic [0:63]      alu_b;
    logic [0:63]      alu_dout;

    logic             res_valid;
    logic             res_ready;
    logic [0:63]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;

    logic             busy;

    modport slave (
        input  req_valid, req_type, req_ww, req_imm, req_a, req_b, req_tag,
        input  alu_dout, res_ready,
        output req_ready,
        output alu_en, alu_type, alu_ww, alu_imm, alu_a, alu_b,
        output res_valid, res_data, res_tag, res_err, busy
    );

    modport master (
        output req_valid, req_type, req_ww, req_imm, req_a, req_b, req_tag,
        output alu_dout, res_ready,
        input  req_ready,
        input  alu_en, alu_type, alu_ww, alu_imm, alu_a, alu_b,
        input  res_valid, res_data, res_tag, res_err, busy
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - one-op-at-a-time sequencer in front of the multicycle SIMD ALU
//
// Ports:
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset
//   bus      : alu_seq_ctrl_if.slave (issue handshake, ALU drive, writeback handshake, busy)
// Parameters:
//   ADD_LAT  : ALU hold cycles for add/sub (1..15)
//   MUL_LAT  : ALU hold cycles for mul-even/mul-odd (1..15)
//   TAG_W    : destination tag width
module alu_seq_ctrl #(
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 3,
    parameter int TAG_W   = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_seq_ctrl_if.slave  bus
);
    localparam logic [0:5] OP_ADD  = 6'b000101;
    localparam logic [0:5] OP_SUB  = 6'b000110;
    localparam logic [0:5] OP_MULO = 6'b000111;
    localparam logic [0:5] OP_MULE = 6'b001000;

    localparam logic [3:0] ADD_CNT = 4'(ADD_LAT - 1);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_alu_en;
    logic [0:5]       r_alu_type;
    logic [0:1]       r_alu_ww;
    logic [0:4]       r_alu_imm;
    logic [0:63]      r_alu_a;
    logic [0:63]      r_alu_b;
    logic             r_res_valid;
    logic [0:63]      r_res_data;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_err;
    logic             r_busy;

    logic             w_req_ready;
    logic             w_accept;
    logic             w_supported;
    logic [3:0]       w_load_cnt;

    // DONE can take a new op in the same cycle its result is consumed.
    assign w_req_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.res_ready);
    assign w_accept    = bus.req_valid && w_req_ready;

    always_comb begin
        w_supported = 1'b0;
        w_load_cnt  = 4'd0;
        case (bus.req_type)
            OP_ADD, OP_SUB: begin
                w_supported = 1'b1;
                w_load_cnt  = ADD_CNT;
            end
            OP_MULE, OP_MULO: begin
                w_supported = 1'b1;
                w_load_cnt  = MUL_CNT;
            end
            default: begin
                w_supported = 1'b0;
                w_load_cnt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_alu_en    <= 1'b0;
            r_alu_type  <= '0;
            r_alu_ww    <= '0;
            r_alu_imm   <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_res_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_alu_type <= bus.req_type;
                        r_alu_ww   <= bus.req_ww;
                        r_alu_imm  <= bus.req_imm;
                        r_alu_a    <= bus.req_a;
                        r_alu_b    <= bus.req_b;
                        r_res_tag  <= bus.req_tag;
                        r_busy     <= 1'b1;
                        if (w_supported) begin
                            r_state     <= ST_EXEC;
                            r_cnt       <= w_load_cnt;
                            r_alu_en    <= 1'b1;
                            r_res_valid <= 1'b0;
                        end else begin
                            // Unsupported ops never touch the ALU; report straight away.
                            r_state     <= ST_DONE;
                            r_alu_en    <= 1'b0;
                            r_res_valid <= 1'b1;
                            r_res_data  <= '0;
                            r_res_err   <= 1'b1;
                        end
                    end else if ((r_state == ST_DONE) && bus.res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_DONE;
                        r_alu_en    <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_res_data  <= bus.alu_dout;
                        r_res_err   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_alu_en    <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.alu_en    = r_alu_en;
    assign bus.alu_type  = r_alu_type;
    assign bus.alu_ww    = r_alu_ww;
    assign bus.alu_imm   = r_alu_imm;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_tag   = r_res_tag;
    assign bus.res_err   = r_res_err;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;
    localparam int ADD_LAT = 1;
    localparam int MUL_LAT = 3;
    localparam int TAG_W   = 5;

    localparam logic [0:5]  OP_ADD  = 6'b000101;
    localparam logic [0:5]  OP_SUB  = 6'b000110;
    localparam logic [0:5]  OP_MULO = 6'b000111;
    localparam logic [0:5]  OP_MULE = 6'b001000;
    localparam logic [0:63] POISON  = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk;
    logic reset_n;

    alu_seq_ctrl_if #(.TAG_W(TAG_W)) bus ();

    alu_seq_ctrl #(
        .ADD_LAT(ADD_LAT),
        .MUL_LAT(MUL_LAT),
        .TAG_W  (TAG_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [0:5] t);
        case (t)
            OP_ADD, OP_SUB:   return ADD_LAT;
            OP_MULE, OP_MULO: return MUL_LAT;
            default:          return 0;
        endcase
    endfunction

    // Stand-in ALU: only needs distinct, deterministic results per opcode.
    function automatic logic [0:63] alu_ref(input logic [0:5] t, input logic [0:63] a,
                                            input logic [0:63] b);
        logic [0:63] r;
        r = POISON;
        case (t)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_MULE, OP_MULO: begin
                for (int i = 0; i < 4; i++)
                    r[16*i +: 16] = 16'(a[16*i +: 16] * b[16*i +: 16]);
                if (t == OP_MULO) r = r ^ 64'h0001_0001_0001_0001;
            end
            default: r = POISON;
        endcase
        return r;
    endfunction

    // The stub ALU only shows a valid result on the last held cycle, so a
    // result sampled on any other edge is visibly wrong.
    int en_run;
    always @(posedge clk) en_run <= bus.alu_en ? en_run + 1 : 0;
    assign bus.alu_dout = (bus.alu_en && (en_run == lat_of(bus.alu_type) - 1))
                          ? alu_ref(bus.alu_type, bus.alu_a, bus.alu_b) : POISON;

    // Behavioural model: an op either occupies the ALU for a number of cycles
    // or sits as a pending result waiting for writeback.
    bit               m_started   = 1'b0;
    bit               m_acc_evt   = 1'b0;
    int               m_exec_left = 0;
    bit               m_have      = 1'b0;
    logic [0:5]       m_type      = '0;
    logic [0:1]       m_ww        = '0;
    logic [0:4]       m_imm       = '0;
    logic [0:63]      m_a         = '0;
    logic [0:63]      m_b         = '0;
    logic [TAG_W-1:0] m_tag       = '0;
    logic [0:63]      m_res       = '0;
    bit               m_err       = 1'b0;

    always @(posedge clk) begin
        automatic bit rdy = (m_exec_left == 0) && (!m_have || bus.res_ready);
        m_acc_evt = 1'b0;
        if (!reset_n) begin
            m_exec_left = 0;
            m_have = 0; m_type = '0; m_ww = '0; m_imm = '0;
            m_a = '0; m_b = '0; m_tag = '0; m_res = '0; m_err = 0;
        end else if (m_exec_left > 0) begin
            m_exec_left--;
            if (m_exec_left == 0) begin
                m_res  = alu_ref(m_type, m_a, m_b);
                m_err  = 1'b0;
                m_have = 1'b1;
            end
        end else begin
            if (m_have && bus.res_ready) m_have = 1'b0;
            if (bus.req_valid && rdy) begin
                m_acc_evt = 1'b1;
                m_type = bus.req_type; m_ww = bus.req_ww; m_imm = bus.req_imm;
                m_a = bus.req_a; m_b = bus.req_b; m_tag = bus.req_tag;
                if (lat_of(bus.req_type) > 0) begin
                    m_exec_left = lat_of(bus.req_type);
                end else begin
                    m_res  = '0;
                    m_err  = 1'b1;
                    m_have = 1'b1;
                end
            end
        end
        m_started = 1'b1;
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("req_ready", bus.req_ready,
                64'((m_exec_left == 0) && (!m_have || bus.res_ready)));
            chk("alu_en",    bus.alu_en,    64'(m_exec_left > 0));
            chk("alu_type",  bus.alu_type,  m_type);
            chk("alu_ww",    bus.alu_ww,    m_ww);
            chk("alu_imm",   bus.alu_imm,   m_imm);
            chk("alu_a",     bus.alu_a,     m_a);
            chk("alu_b",     bus.alu_b,     m_b);
            chk("res_valid", bus.res_valid, m_have);
            chk("res_data",  bus.res_data,  m_res);
            chk("res_tag",   bus.res_tag,   m_tag);
            chk("res_err",   bus.res_err,   m_err);
            chk("busy",      bus.busy,      64'((m_exec_left > 0) || m_have));
        end
    end

    int en_cycles = 0;
    always @(negedge clk) if (bus.alu_en === 1'b1) en_cycles++;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [0:5] t, input logic [0:1] ww, input logic [0:4] imm,
                        input logic [0:63] a, input logic [0:63] b,
                        input logic [TAG_W-1:0] tag);
        int n;
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_ww    = ww;
        bus.req_imm   = imm;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc_evt && n < 50);
        if (!m_acc_evt) chk("accept_timeout", 64'd0, 64'd1);
        bus.req_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until res_valid is seen.
    task automatic wait_res(output int n);
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (bus.res_valid !== 1'b1) chk("res_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        bit seen;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_type  = '0;
        bus.req_ww    = '0;
        bus.req_imm   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.res_ready = 1'b0;
        repeat (3) tick();
        chk("rst_res_valid", bus.res_valid, 64'd0);
        chk("rst_alu_en",    bus.alu_en,    64'd0);
        chk("rst_busy",      bus.busy,      64'd0);
        chk("rst_res_data",  bus.res_data,  64'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_req_ready", bus.req_ready, 64'd1);

        // Add, 1-cycle latency.
        en_cycles = 0;
        send(OP_ADD, 2'b00, 5'd0, 64'h5, 64'h3, 5'd7);
        wait_res(n);
        chk("add_latency",   n,            64'd1);
        chk("add_en_cycles", en_cycles,    64'd1);
        chk("add_data",      bus.res_data, 64'h8);
        chk("add_tag",       bus.res_tag,  64'd7);
        chk("add_err",       bus.res_err,  64'd0);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        // Mul-even, 3-cycle latency.
        en_cycles = 0;
        send(OP_MULE, 2'b00, 5'd1, 64'h0003_0003_0003_0003, 64'h0004_0004_0004_0004, 5'd1);
        wait_res(n);
        chk("mule_latency",   n,            64'd3);
        chk("mule_en_cycles", en_cycles,    64'd3);
        chk("mule_data",      bus.res_data, 64'h000C_000C_000C_000C);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        // Sub under backpressure, then back-to-back mul-odd.
        send(OP_SUB, 2'b01, 5'd2, 64'h10, 64'h4, 5'd9);
        wait_res(n);
        bus.req_valid = 1'b1;
        bus.req_type  = OP_MULO;
        bus.req_ww    = 2'b10;
        bus.req_imm   = 5'd3;
        bus.req_a     = 64'h0002_0002_0002_0002;
        bus.req_b     = 64'h0003_0003_0003_0003;
        bus.req_tag   = 5'd11;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_data",      bus.res_data,  64'h0C);
            chk("bp_tag",       bus.res_tag,   64'd9);
            chk("bp_req_ready", bus.req_ready, 64'd0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk("b2b_alu_en",    bus.alu_en,    64'd1);
        chk("b2b_res_valid", bus.res_valid, 64'd0);
        chk("b2b_alu_type",  bus.alu_type,  64'(OP_MULO));
        wait_res(n);
        chk("mulo_latency", n,            64'd3);
        chk("mulo_data",    bus.res_data, 64'h0007_0007_0007_0007);
        chk("mulo_tag",     bus.res_tag,  64'd11);
        tick();
        bus.res_ready = 1'b0;

        // Unsupported opcode.
        en_cycles = 0;
        send(6'b111111, 2'b00, 5'd0, 64'h1234, 64'h5678, 5'd3);
        wait_res(n);
        chk("unsup_latency", n,            64'd0);
        chk("unsup_data",    bus.res_data, 64'd0);
        chk("unsup_err",     bus.res_err,  64'd1);
        chk("unsup_tag",     bus.res_tag,  64'd3);
        chk("unsup_en",      en_cycles,    64'd0);
        // Unsupported ops back-to-back at one per cycle.
        bus.res_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_type  = 6'b111110;
        bus.req_tag   = 5'd4;
        tick();
        bus.req_tag   = 5'd5;
        tick();
        chk("unsup_b2b_tag", bus.res_tag, 64'd5);
        bus.req_valid = 1'b0;
        tick();
        tick();

        // Reset during the second EXEC cycle of a mul.
        send(OP_MULE, 2'b11, 5'd4, 64'h0001_0001_0001_0001, 64'h0009_0009_0009_0009, 5'd13);
        tick();
        reset_n = 1'b0;
        tick();
        chk("mid_rst_alu_en",    bus.alu_en,    64'd0);
        chk("mid_rst_res_valid", bus.res_valid, 64'd0);
        chk("mid_rst_busy",      bus.busy,      64'd0);
        chk("mid_rst_alu_a",     bus.alu_a,     64'd0);
        chk("mid_rst_alu_type",  bus.alu_type,  64'd0);
        chk("mid_rst_res_tag",   bus.res_tag,   64'd0);
        chk("mid_rst_req_ready", bus.req_ready, 64'd1);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.res_valid === 1'b1) seen = 1'b1;
        end
        chk("mid_rst_no_result", seen, 64'd0);

        // Request inputs changing during EXEC must be ignored.
        bus.res_ready = 1'b0;
        send(OP_MULE, 2'b00, 5'd5, 64'h0002_0002_0002_0002, 64'h0005_0005_0005_0005, 5'd12);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_type = (i % 2 == 0) ? OP_ADD : OP_SUB;
            bus.req_a    = 64'hFFFF_0000_FFFF_0000 ^ 64'(i);
            bus.req_b    = 64'h1111_2222_3333_4444 + 64'(i);
            bus.req_tag  = 5'(20 + i);
            tick();
        end
        wait_res(n);
        bus.req_valid = 1'b0;
        chk("ign_data",     bus.res_data, 64'h000A_000A_000A_000A);
        chk("ign_tag",      bus.res_tag,  64'd12);
        chk("ign_alu_type", bus.alu_type, 64'(OP_MULE));
        bus.res_ready = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
